// File: rtl/depp_pkg.sv
// Shared definitions for the DEPP memory bridge: FSM states,
// address-register fields and parameter sanity checks.
package depp_pkg;

   typedef enum logic [2:0] {
      ST_READY,
      ST_AWR,
      ST_ARD,
      ST_DWR,
      ST_DRD,
      ST_DRDW,
      ST_ACK
   } state_t;

   localparam int WIN_BIT = 7;
   localparam int INC_BIT = 6;
   localparam int SEL_HI  = 1;
   localparam int SEL_LO  = 0;

   function automatic logic addr_w_ok(input int w);
      return (w >= 8) && (w <= 32) && (w % 8 == 0);
   endfunction

   function automatic logic rd_lat_ok(input int l);
      return (l >= 1) && (l <= 4);
   endfunction

   function automatic logic sync_ok(input int s);
      return (s >= 0) && (s <= 15);
   endfunction

endpackage

// File: rtl/depp_sync.sv
// Multi-stage synchronizer for the EPP control pins; resets to
// all-ones so the strobes read as idle.
module depp_sync #(
   parameter int STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] d,
   output logic [2:0] q
);

   if (STAGES == 0) begin : g_bypass
      assign q = d;
   end else begin : g_sync
      logic [2:0] r [STAGES];

      always_ff @(posedge clk) begin
         if (rst) begin
            for (int i = 0; i < STAGES; i++) r[i] <= 3'b111;
         end else begin
            r[0] <= d;
            for (int i = 1; i < STAGES; i++) r[i] <= r[i-1];
         end
      end

      assign q = r[STAGES-1];
   end

endmodule

// File: rtl/depp_mem_bridge.sv
// DEPP slave bridging host EPP cycles onto a synchronous memory
// through an 8-bit address register and a byte-loadable pointer.
module depp_mem_bridge
   import depp_pkg::*;
#(
   parameter int ADDR_W      = 16,
   parameter int RD_LAT      = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   inout  wire  [7:0]        depp_db,
   input  logic              depp_astb,
   input  logic              depp_dstb,
   input  logic              depp_write,
   output logic              depp_wait,
   output logic              depp_mem_we,
   output logic              depp_mem_re,
   output logic [ADDR_W-1:0] depp_mem_adr,
   output logic [7:0]        depp_mem_idata,
   input  logic [7:0]        depp_mem_odata
);

   if (!addr_w_ok(ADDR_W) || !rd_lat_ok(RD_LAT) ||
       !sync_ok(SYNC_STAGES)) begin : g_bad_param
      $error("depp_mem_bridge: parameter out of range");
   end

   localparam int         NBYTES   = ADDR_W / 8;
   localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);
   localparam logic [3:0] HOLD     = 4'(SYNC_STAGES);

   logic [2:0] sync_q;
   logic       astb;
   logic       dstb;
   logic       hwrite;

   depp_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   ({depp_astb, depp_dstb, depp_write}),
      .q   (sync_q)
   );

   assign {astb, dstb, hwrite} = sync_q;

   state_t            state;
   logic [7:0]        areg;
   logic [7:0]        dout;
   logic [ADDR_W-1:0] ptr;
   logic [1:0]        lat_cnt;
   logic [3:0]        hold;
   logic              armed;
   logic              addr_cyc;
   logic              rd_cyc;
   logic [1:0]        sel;
   logic              win;
   logic [7:0]        ptr_byte;

   assign sel = areg[SEL_HI:SEL_LO];
   assign win = areg[WIN_BIT];

   // Out-of-range byte selects fall through to zero.
   always_comb begin
      ptr_byte = 8'h00;
      for (int k = 0; k < NBYTES; k++)
         if (int'(sel) == k) ptr_byte = ptr[8*k +: 8];
   end

   assign depp_mem_adr = ptr;
   assign depp_db = (depp_write && rd_cyc && state == ST_ACK) ?
                    dout : 8'hzz;

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= ST_READY;
         areg           <= 8'h00;
         ptr            <= '0;
         dout           <= 8'hFF;
         depp_mem_idata <= 8'h00;
         depp_mem_we    <= 1'b0;
         depp_mem_re    <= 1'b0;
         depp_wait      <= 1'b0;
         lat_cnt        <= 2'd0;
         hold           <= HOLD;
         armed          <= 1'b0;
         addr_cyc       <= 1'b0;
         rd_cyc         <= 1'b0;
      end else begin
         depp_mem_we <= 1'b0;
         depp_mem_re <= 1'b0;
         if (hold != 4'd0) hold <= hold - 4'd1;

         unique case (state)
            ST_READY: begin
               // After reset, wait for flushed, idle strobes.
               if (!armed) begin
                  if (hold == 4'd0 && astb && dstb) armed <= 1'b1;
               end else if (!astb) begin
                  addr_cyc <= 1'b1;
                  rd_cyc   <= hwrite;
                  state    <= hwrite ? ST_ARD : ST_AWR;
               end else if (!dstb) begin
                  addr_cyc <= 1'b0;
                  rd_cyc   <= hwrite;
                  if (hwrite) begin
                     depp_mem_re <= win;
                     state       <= ST_DRD;
                  end else begin
                     state <= ST_DWR;
                  end
               end
            end
            ST_AWR: begin
               areg      <= depp_db;
               depp_wait <= 1'b1;
               state     <= ST_ACK;
            end
            ST_ARD: begin
               dout      <= areg;
               depp_wait <= 1'b1;
               state     <= ST_ACK;
            end
            ST_DWR: begin
               depp_mem_idata <= depp_db;
               if (win) begin
                  depp_mem_we <= 1'b1;
               end else begin
                  for (int k = 0; k < NBYTES; k++)
                     if (int'(sel) == k) ptr[8*k +: 8] <= depp_db;
               end
               depp_wait <= 1'b1;
               state     <= ST_ACK;
            end
            ST_DRD: begin
               if (win) begin
                  lat_cnt <= LAT_INIT;
                  state   <= ST_DRDW;
               end else begin
                  dout      <= ptr_byte;
                  depp_wait <= 1'b1;
                  state     <= ST_ACK;
               end
            end
            ST_DRDW: begin
               if (lat_cnt == 2'd0) begin
                  dout      <= depp_mem_odata;
                  depp_wait <= 1'b1;
                  state     <= ST_ACK;
               end else begin
                  lat_cnt <= lat_cnt - 2'd1;
               end
            end
            ST_ACK: begin
               if (addr_cyc ? astb : dstb) begin
                  depp_wait <= 1'b0;
                  state     <= ST_READY;
                  if (!addr_cyc && win && areg[INC_BIT])
                     ptr <= ptr + 1'b1;
               end
            end
            default: state <= ST_READY;
         endcase
      end
   end

endmodule

// File: tb/tb_depp_mem_bridge.sv
// Directed bench for depp_mem_bridge: EPP host model plus a
// pipelined memory returning adr[7:0]^5A after RD_LAT cycles.
module tb_depp_mem_bridge;

   localparam int ADDR_W = 16;
   localparam int RD_LAT = 3;
   localparam int SYNC   = 2;
   localparam int LAT_W  = SYNC + 2;
   localparam int LAT_MR = SYNC + 2 + RD_LAT;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              depp_astb = 1'b1;
   logic              depp_dstb = 1'b1;
   logic              depp_write = 1'b0;
   logic              depp_wait;
   logic              depp_mem_we;
   logic              depp_mem_re;
   logic [ADDR_W-1:0] depp_mem_adr;
   logic [7:0]        depp_mem_idata;
   logic [7:0]        depp_mem_odata;
   logic [7:0]        host_d = 8'h00;
   logic              host_oe = 1'b0;
   wire  [7:0]        depp_db;

   int checks = 0;
   int errors = 0;

   assign depp_db = host_oe ? host_d : 8'hzz;

   always #5 clk = ~clk;

   depp_mem_bridge #(
      .ADDR_W      (ADDR_W),
      .RD_LAT      (RD_LAT),
      .SYNC_STAGES (SYNC)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .depp_db        (depp_db),
      .depp_astb      (depp_astb),
      .depp_dstb      (depp_dstb),
      .depp_write     (depp_write),
      .depp_wait      (depp_wait),
      .depp_mem_we    (depp_mem_we),
      .depp_mem_re    (depp_mem_re),
      .depp_mem_adr   (depp_mem_adr),
      .depp_mem_idata (depp_mem_idata),
      .depp_mem_odata (depp_mem_odata)
   );

   logic       v1 = 1'b0, v2 = 1'b0, v3 = 1'b0;
   logic [7:0] d1 = 8'h00, d2 = 8'h00, d3 = 8'h00;

   always @(posedge clk) begin
      v1 <= depp_mem_re;
      d1 <= depp_mem_adr[7:0] ^ 8'h5A;
      v2 <= v1;
      d2 <= d1;
      v3 <= v2;
      d3 <= d2;
   end

   assign depp_mem_odata = v3 ? d3 : 8'hEE;

   int          we_n = 0;
   int          re_n = 0;
   logic [15:0] we_adr[$];
   logic [7:0]  we_dat[$];

   always @(posedge clk) begin
      if (depp_mem_we) begin
         we_n <= we_n + 1;
         we_adr.push_back(depp_mem_adr);
         we_dat.push_back(depp_mem_idata);
      end
      if (depp_mem_re) re_n <= re_n + 1;
   end

   task automatic epp(input bit is_addr, input bit is_read,
                      input logic [7:0] wd,
                      output logic [7:0] rd, output int lat);
      bit done;
      @(negedge clk);
      depp_write = is_read;
      host_oe    = !is_read;
      host_d     = wd;
      if (is_addr) depp_astb = 1'b0;
      else         depp_dstb = 1'b0;
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (depp_wait) begin
            lat = i;
            break;
         end
      end
      rd = depp_db;
      @(negedge clk);
      depp_astb = 1'b1;
      depp_dstb = 1'b1;
      done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (!depp_wait) begin
            done = 1'b1;
            break;
         end
      end
      host_oe = 1'b0;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL release_timeout: wait=%b required 0", depp_wait);
      end
   endtask

   task automatic test_reset;
      checks++;
      if (depp_wait !== 1'b0) begin
         errors++;
         $display("FAIL rst_wait: got %b required 0", depp_wait);
      end
      checks++;
      if ({depp_mem_we, depp_mem_re} !== 2'b00) begin
         errors++;
         $display("FAIL rst_we_re: got %b%b required 00",
                  depp_mem_we, depp_mem_re);
      end
      checks++;
      if (depp_mem_adr !== 16'h0000) begin
         errors++;
         $display("FAIL rst_adr: got %h required 0000", depp_mem_adr);
      end
      checks++;
      if (depp_mem_idata !== 8'h00) begin
         errors++;
         $display("FAIL rst_idata: got %h required 00", depp_mem_idata);
      end
   endtask

   task automatic test_addr_rw;
      logic [7:0] rd;
      int         lat;
      epp(1, 0, 8'hC0, rd, lat);
      checks++;
      if (lat !== LAT_W) begin
         errors++;
         $display("FAIL awr_lat: got %0d required %0d", lat, LAT_W);
      end
      epp(1, 1, 8'h00, rd, lat);
      checks++;
      if (lat !== LAT_W) begin
         errors++;
         $display("FAIL ard_lat: got %0d required %0d", lat, LAT_W);
      end
      checks++;
      if (rd !== 8'hC0) begin
         errors++;
         $display("FAIL ard_data: got %h required c0", rd);
      end
      @(negedge clk);
      depp_write = 1'b1;
      host_d     = 8'h00;
      host_oe    = 1'b1;
      #1;
      checks++;
      if (depp_db !== 8'h00) begin
         errors++;
         $display("FAIL bus_release: got %h required 00", depp_db);
      end
      host_oe = 1'b0;
      checks++;
      if (depp_mem_adr !== 16'h0000) begin
         errors++;
         $display("FAIL awr_ptr: got %h required 0000", depp_mem_adr);
      end
   endtask

   task automatic test_burst_write;
      logic [7:0] rd;
      int         lat;
      int         base;
      logic [7:0] dat [3];
      dat[0] = 8'hAA;
      dat[1] = 8'hBB;
      dat[2] = 8'hCC;
      epp(1, 0, 8'h00, rd, lat);
      epp(0, 0, 8'h34, rd, lat);
      epp(1, 0, 8'h01, rd, lat);
      epp(0, 0, 8'h12, rd, lat);
      epp(1, 0, 8'hC0, rd, lat);
      base = we_n;
      for (int i = 0; i < 3; i++) epp(0, 0, dat[i], rd, lat);
      checks++;
      if (we_n - base !== 3) begin
         errors++;
         $display("FAIL burst_we_count: got %0d required 3", we_n - base);
      end
      for (int i = 0; i < 3; i++) begin
         if (we_n - base == 3) begin
            checks++;
            if (we_adr[base+i] !== 16'h1234 + 16'(i) ||
                we_dat[base+i] !== dat[i]) begin
               errors++;
               $display("FAIL burst_we%0d: got %h/%h required %h/%h", i,
                        we_adr[base+i], we_dat[base+i],
                        16'h1234 + 16'(i), dat[i]);
            end
         end
      end
      checks++;
      if (depp_mem_adr !== 16'h1237) begin
         errors++;
         $display("FAIL burst_ptr: got %h required 1237", depp_mem_adr);
      end
      checks++;
      if (depp_mem_idata !== 8'hCC) begin
         errors++;
         $display("FAIL burst_idata: got %h required cc", depp_mem_idata);
      end
      epp(1, 0, 8'h00, rd, lat);
      epp(0, 1, 8'h00, rd, lat);
      checks++;
      if (rd !== 8'h37 || lat !== LAT_W) begin
         errors++;
         $display("FAIL ptr_byte0: got %h lat %0d required 37 lat %0d",
                  rd, lat, LAT_W);
      end
      epp(1, 0, 8'h01, rd, lat);
      epp(0, 1, 8'h00, rd, lat);
      checks++;
      if (rd !== 8'h12) begin
         errors++;
         $display("FAIL ptr_byte1: got %h required 12", rd);
      end
   endtask

   task automatic test_window_read;
      logic [7:0] rd;
      int         lat;
      int         base;
      epp(1, 0, 8'h00, rd, lat);
      epp(0, 0, 8'h00, rd, lat);
      epp(1, 0, 8'h01, rd, lat);
      epp(0, 0, 8'h00, rd, lat);
      epp(1, 0, 8'h80, rd, lat);
      base = re_n;
      epp(0, 1, 8'h00, rd, lat);
      checks++;
      if (lat !== LAT_MR) begin
         errors++;
         $display("FAIL wrd_lat: got %0d required %0d", lat, LAT_MR);
      end
      checks++;
      if (rd !== 8'h5A) begin
         errors++;
         $display("FAIL wrd_data: got %h required 5a", rd);
      end
      checks++;
      if (re_n - base !== 1) begin
         errors++;
         $display("FAIL wrd_re_count: got %0d required 1", re_n - base);
      end
      checks++;
      if (depp_mem_adr !== 16'h0000) begin
         errors++;
         $display("FAIL wrd_ptr: got %h required 0000", depp_mem_adr);
      end
   endtask

   task automatic test_wrap;
      logic [7:0] rd;
      int         lat;
      int         base;
      epp(1, 0, 8'h00, rd, lat);
      epp(0, 0, 8'hFF, rd, lat);
      epp(1, 0, 8'h01, rd, lat);
      epp(0, 0, 8'hFF, rd, lat);
      epp(1, 0, 8'hC0, rd, lat);
      base = we_n;
      epp(0, 0, 8'h11, rd, lat);
      checks++;
      if (we_n - base !== 1) begin
         errors++;
         $display("FAIL wrap_we_count: got %0d required 1", we_n - base);
      end else begin
         checks++;
         if (we_adr[base] !== 16'hFFFF || we_dat[base] !== 8'h11) begin
            errors++;
            $display("FAIL wrap_we: got %h/%h required ffff/11",
                     we_adr[base], we_dat[base]);
         end
      end
      checks++;
      if (depp_mem_adr !== 16'h0000) begin
         errors++;
         $display("FAIL wrap_ptr: got %h required 0000", depp_mem_adr);
      end
   endtask

   task automatic test_out_of_range;
      logic [7:0] rd;
      int         lat;
      int         wb;
      int         rb;
      epp(1, 0, 8'h03, rd, lat);
      wb = we_n;
      rb = re_n;
      epp(0, 0, 8'h77, rd, lat);
      epp(0, 1, 8'h00, rd, lat);
      checks++;
      if (rd !== 8'h00) begin
         errors++;
         $display("FAIL oor_read: got %h required 00", rd);
      end
      checks++;
      if (we_n != wb || re_n != rb) begin
         errors++;
         $display("FAIL oor_strobes: got we %0d re %0d required 0 0",
                  we_n - wb, re_n - rb);
      end
      checks++;
      if (depp_mem_adr !== 16'h0000) begin
         errors++;
         $display("FAIL oor_ptr: got %h required 0000", depp_mem_adr);
      end
   endtask

   task automatic test_reset_drdw;
      logic [7:0] rd;
      int         lat;
      int         wb;
      int         seen;
      epp(1, 0, 8'h80, rd, lat);
      wb = we_n;
      @(negedge clk);
      depp_write = 1'b1;
      depp_dstb  = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst  = 1'b0;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (depp_wait) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL rst_drdw_wait: high %0d cycles required 0", seen);
      end
      checks++;
      if (we_n != wb) begin
         errors++;
         $display("FAIL rst_drdw_we: got %0d pulses required 0", we_n - wb);
      end
      @(negedge clk);
      depp_dstb = 1'b1;
      repeat (6) @(posedge clk);
      epp(1, 0, 8'hC0, rd, lat);
      epp(1, 1, 8'h00, rd, lat);
      checks++;
      if (rd !== 8'hC0 || lat !== LAT_W) begin
         errors++;
         $display("FAIL rst_drdw_next: got %h lat %0d required c0 lat %0d",
                  rd, lat, LAT_W);
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      test_reset;
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(posedge clk);
      test_addr_rw;
      test_burst_write;
      test_window_read;
      test_wrap;
      test_out_of_range;
      test_reset_drdw;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
